count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_pkg.sv | 26 ++
 rtl/count_monitor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pkg
// Description : Shared definitions for the count-sequence source and the
//               count monitor. Holds the count width, the default last value
//               of a pass, and the monitor state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package count_pkg;

   // Width of every count value on the sequence bus
   localparam int c_COUNT_W       = 4;

   // Default last value of each 0..MAX_COUNT pass
   localparam int c_MAX_COUNT_DEF = 7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRACK = 3'd1,
      ST_HOLD  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } mon_state_t;

endpackage : count_pkg
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor
// Description : Watches a count-sequence stream. After locking on a 0 it
//               requires NUM_PASSES complete 0..MAX_COUNT passes, followed by
//               HOLD_CYCLES further MAX_COUNT samples, and then raises Done.
//               Any out-of-sequence sample moves it to a sticky error state.
//               All outputs are registered; a sample accepted on one edge is
//               visible on the outputs right after that edge.
// Ports       : Clk        in   clock, rising edge
//               Rst        in   synchronous active-high reset
//               CountValid in   CountIn is sampled this cycle
//               CountIn    in   count value from the sequence source
//               Expected   out  next value the monitor will accept
//               PassNum    out  0-based index of the pass in progress
//               Locked     out  monitor has seen a 0 and is tracking
//               SeqErr     out  sequence violation detected
//               Done       out  full sequence plus hold observed
// Config      : COUNT_MONITOR_RESYNC_EN - when defined, a valid 0 received
//               in the error state restarts tracking from pass 0. When not
//               defined, the error state is left only by Rst.
// Revision    : 1.0  initial release
// ============================================================================
module count_monitor
   import count_pkg::*;
#(
   parameter int MAX_COUNT   = c_MAX_COUNT_DEF,
   parameter int NUM_PASSES  = 3,   // legal 1..4
   parameter int HOLD_CYCLES = 2    // legal 1..15
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 CountValid,
   input  logic [c_COUNT_W-1:0] CountIn,
   output logic [c_COUNT_W-1:0] Expected,
   output logic [1:0]           PassNum,
   output logic                 Locked,
   output logic                 SeqErr,
   output logic                 Done
);

   localparam int                 c_LAST_PASS_I = NUM_PASSES - 1;
   localparam logic [c_COUNT_W-1:0] c_MAX       = MAX_COUNT[c_COUNT_W-1:0];
   localparam logic [1:0]         c_LAST_PASS   = c_LAST_PASS_I[1:0];
   localparam logic [3:0]         c_HOLD        = HOLD_CYCLES[3:0];
   localparam logic [c_COUNT_W-1:0] c_ONE       = c_COUNT_W'(1);

   mon_state_t           r_state;
   logic [c_COUNT_W-1:0] r_expected;
   logic [1:0]           r_pass;
   logic                 r_locked;
   logic                 r_seq_err;
   logic                 r_done;
   logic [3:0]           r_hold_cnt;

   logic                 w_mismatch;
   logic [3:0]           w_hold_next;

   // Values above MAX_COUNT can never equal Expected, so they fall out as a
   // plain mismatch rather than needing a separate range check.
   assign w_mismatch  = (CountIn != r_expected);
   assign w_hold_next = r_hold_cnt + 4'd1;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state    <= ST_IDLE;
         r_expected <= '0;
         r_pass     <= '0;
         r_locked   <= 1'b0;
         r_seq_err  <= 1'b0;
         r_done     <= 1'b0;
         r_hold_cnt <= '0;
      end else if (CountValid) begin
         case (r_state)
            ST_IDLE: begin
               // Anything other than 0 is noise before lock, not an error
               if (CountIn == '0) begin
                  r_state    <= ST_TRACK;
                  r_expected <= c_ONE;
                  r_locked   <= 1'b1;
               end
            end

            ST_ERR: begin
`ifdef COUNT_MONITOR_RESYNC_EN
               if (CountIn == '0) begin
                  r_state    <= ST_TRACK;
                  r_expected <= c_ONE;
                  r_pass     <= '0;
                  r_locked   <= 1'b1;
                  r_seq_err  <= 1'b0;
               end
`endif
            end

            default: begin
               // TRACK, HOLD and DONE share the same mismatch handling;
               // Expected and PassNum are left frozen at the failing point.
               if (w_mismatch) begin
                  r_state   <= ST_ERR;
                  r_seq_err <= 1'b1;
                  r_done    <= 1'b0;
                  r_locked  <= 1'b0;
               end else if (r_state == ST_TRACK) begin
                  if (r_expected != c_MAX) begin
                     r_expected <= r_expected + c_ONE;
                  end else if (r_pass != c_LAST_PASS) begin
                     r_pass     <= r_pass + 2'd1;
                     r_expected <= '0;
                  end else begin
                     // Final pass complete; Expected stays at MAX_COUNT
                     r_state    <= ST_HOLD;
                     r_hold_cnt <= '0;
                  end
               end else if (r_state == ST_HOLD) begin
                  r_hold_cnt <= w_hold_next;
                  if (w_hold_next == c_HOLD) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
               // DONE with a matching MAX_COUNT sample: nothing changes
            end
         endcase
      end
   end

   assign Expected = r_expected;
   assign PassNum  = r_pass;
   assign Locked   = r_locked;
   assign SeqErr   = r_seq_err;
   assign Done     = r_done;

endmodule : count_monitor
`default_nettype wire
